// File: rtl/dac_rst_sequencer.sv
// Avalon-MM slave that owns the DAC reset pin and runs a timed reset/settle
// sequence on software START, with programmable pulse and settle lengths.
module dac_rst_sequencer #(
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned PULSE_DEFAULT  = 100,
  parameter int unsigned SETTLE_DEFAULT = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        dac_rst,
  output logic        dac_ready,
  output logic        irq
);

  localparam logic [1:0] ADDR_CONTROL = 2'd0;
  localparam logic [1:0] ADDR_PULSE   = 2'd1;
  localparam logic [1:0] ADDR_SETTLE  = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  typedef enum logic [1:0] {
    ST_HOLD   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_SETTLE = 2'd2,
    ST_READY  = 2'd3
  } state_t;

  state_t             state_q, state_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic [CNT_W-1:0]   settle_snap_q, settle_snap_nxt;
  logic [CNT_W-1:0]   pulse_len_q, pulse_len_nxt;
  logic [CNT_W-1:0]   settle_len_q, settle_len_nxt;
  logic               done_q, done_nxt;
  logic               irq_en_q, irq_en_nxt;
  logic               done_set;
  logic               dac_rst_nxt, dac_ready_nxt, irq_nxt;

  logic               wr_en, ctrl_wr, start_req, abort_req, done_clr;
  logic [CNT_W-1:0]   pulse_load, settle_load;
  logic               unused_wd;

  assign wr_en     = chipselect & ~write_n;
  assign ctrl_wr   = wr_en & (address == ADDR_CONTROL);
  assign start_req = ctrl_wr & writedata[0];
  assign abort_req = ctrl_wr & writedata[1];
  assign done_clr  = wr_en & (address == ADDR_STATUS) & writedata[2];
  assign unused_wd = ^writedata;

  // Zero length behaves as a one-cycle phase
  assign pulse_load  = (pulse_len_q   == '0) ? '0 : pulse_len_q   - CNT_W'(1);
  assign settle_load = (settle_snap_q == '0) ? '0 : settle_snap_q - CNT_W'(1);

  // State register and all registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_HOLD;
      cnt_q         <= '0;
      settle_snap_q <= '0;
      pulse_len_q   <= CNT_W'(PULSE_DEFAULT);
      settle_len_q  <= CNT_W'(SETTLE_DEFAULT);
      done_q        <= 1'b0;
      irq_en_q      <= 1'b0;
      dac_rst       <= 1'b1;
      dac_ready     <= 1'b0;
      irq           <= 1'b0;
    end else begin
      state_q       <= state_nxt;
      cnt_q         <= cnt_nxt;
      settle_snap_q <= settle_snap_nxt;
      pulse_len_q   <= pulse_len_nxt;
      settle_len_q  <= settle_len_nxt;
      done_q        <= done_nxt;
      irq_en_q      <= irq_en_nxt;
      dac_rst       <= dac_rst_nxt;
      dac_ready     <= dac_ready_nxt;
      irq           <= irq_nxt;
    end
  end

  // Sequencer next-state, counter, register file and output decode
  always_comb begin
    state_nxt       = state_q;
    cnt_nxt         = cnt_q;
    settle_snap_nxt = settle_snap_q;
    pulse_len_nxt   = pulse_len_q;
    settle_len_nxt  = settle_len_q;
    irq_en_nxt      = irq_en_q;
    done_set        = 1'b0;

    case (state_q)
      ST_HOLD, ST_READY: begin
        if (start_req) begin
          state_nxt       = ST_ASSERT;
          cnt_nxt         = pulse_load;
          settle_snap_nxt = settle_len_q;
        end
      end
      ST_ASSERT: begin
        if (cnt_q == '0) begin
          state_nxt = ST_SETTLE;
          cnt_nxt   = settle_load;
        end else begin
          cnt_nxt = cnt_q - CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_nxt = ST_READY;
          done_set  = 1'b1;
        end else begin
          cnt_nxt = cnt_q - CNT_W'(1);
        end
      end
      default: state_nxt = ST_HOLD;
    endcase

    // ABORT overrides everything, including a completing sequence
    if (abort_req) begin
      state_nxt = ST_HOLD;
      done_set  = 1'b0;
    end

    if (ctrl_wr)
      irq_en_nxt = writedata[2];
    if (wr_en && (address == ADDR_PULSE))
      pulse_len_nxt = writedata[CNT_W-1:0];
    if (wr_en && (address == ADDR_SETTLE))
      settle_len_nxt = writedata[CNT_W-1:0];

    done_nxt      = done_set | (done_q & ~done_clr);
    dac_rst_nxt   = (state_nxt == ST_HOLD) || (state_nxt == ST_ASSERT);
    dac_ready_nxt = (state_nxt == ST_READY);
    irq_nxt       = done_nxt & irq_en_nxt;
  end

  // Zero-wait-state read mux
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CONTROL: readdata[2] = irq_en_q;
      ADDR_PULSE:   readdata[CNT_W-1:0] = pulse_len_q;
      ADDR_SETTLE:  readdata[CNT_W-1:0] = settle_len_q;
      default: begin
        readdata[0]   = (state_q == ST_ASSERT) || (state_q == ST_SETTLE);
        readdata[1]   = (state_q == ST_READY);
        readdata[2]   = done_q;
        readdata[5:4] = state_q;
      end
    endcase
  end

endmodule
